// File: rtl/fixed_pkg.sv
// Shared definitions for the metaball fixed-point divider: default Q-format,
// FSM state encoding and the saturated-magnitude helper.
package fixed_pkg;

  localparam int unsigned FIXED_Q = 15;
  localparam int unsigned FIXED_N = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Largest magnitude representable in an n-bit sign-magnitude word.
  function automatic logic [63:0] sat_mag(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fixed_divider.sv
// Sequential sign-magnitude Q-format divider: restoring shift-subtract, one
// quotient bit per cycle, saturating result with a one-cycle completion pulse.
module fixed_divider
  import fixed_pkg::*;
#(
  parameter int unsigned Q = FIXED_Q,
  parameter int unsigned N = FIXED_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_start,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int unsigned W  = N - 1 + Q;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [N-2:0] SAT = (N-1)'(sat_mag(N));

  div_state_t      state_q;
  logic            sign_q;
  logic [W-1:0]    num_q;
  logic [W-1:0]    num_d;
  logic [N-1:0]    rem_q;
  logic [N-1:0]    rem_d;
  logic [N-2:0]    den_q;
  logic [CW-1:0]   count_q;

  logic [N:0]      trial_c;
  logic            take_c;
  logic            ovf_c;
  logic [N-2:0]    mag_c;

  // One restoring step; num_q shifts dividend bits out and quotient bits in.
  always_comb begin
    trial_c = {rem_q, num_q[W-1]};
    take_c  = (trial_c >= (N+1)'(den_q));
    rem_d   = take_c ? N'(trial_c - (N+1)'(den_q)) : N'(trial_c);
    num_d   = {num_q[W-2:0], take_c};
    ovf_c   = (den_q == '0) || (|num_q[W-1 -: Q]);
    mag_c   = ovf_c ? SAT : num_q[N-2:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      num_q          <= '0;
      rem_q          <= '0;
      den_q          <= '0;
      count_q        <= '0;
      o_quotient_out <= '0;
      o_complete     <= 1'b0;
      o_overflow     <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          o_complete <= 1'b0;
          if (i_start) begin
            sign_q  <= i_dividend[N-1] ^ i_divisor[N-1];
            num_q   <= {i_dividend[N-2:0], {Q{1'b0}}};
            den_q   <= i_divisor[N-2:0];
            rem_q   <= '0;
            count_q <= CW'(W);
            o_busy  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          num_q   <= num_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          // A zero magnitude never carries a sign bit.
          o_quotient_out <= {sign_q & (mag_c != '0), mag_c};
          o_overflow     <= ovf_c;
          o_complete     <= 1'b1;
          o_busy         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: directed cases, randomized operands
// against an arithmetic reference model, held-start throughput and reset abort.
module tb_fixed_divider;

  localparam int unsigned Q = 15;
  localparam int unsigned N = 32;
  localparam int unsigned LAT = N + Q;

  logic          clk;
  logic          rst;
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic          start;
  logic [N-1:0]  quotient;
  logic          complete;
  logic          overflow;
  logic          busy;

  int total = 0;
  int bad   = 0;

  fixed_divider #(.Q(Q), .N(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .i_start        (start),
    .o_quotient_out (quotient),
    .o_complete     (complete),
    .o_overflow     (overflow),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, quotient} from plain integer division of |a|*2^Q by |b|.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, q;
    logic            s, ov;
    logic [30:0]     mag;
    ma = longint'(a[30:0]);
    mb = longint'(b[30:0]);
    s  = a[31] ^ b[31];
    if (mb == 0) begin
      ov = 1'b1; mag = 31'h7FFF_FFFF;
    end else begin
      q = (ma << Q) / mb;
      if (q >= 64'h8000_0000) begin
        ov = 1'b1; mag = 31'h7FFF_FFFF;
      end else begin
        ov = 1'b0; mag = 31'(q);
      end
    end
    if (mag == 0) s = 1'b0;
    return {ov, s, mag};
  endfunction

  // Pulse start, then time the completion from the accepting edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic exp_ov, input string tag);
    int cycles;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    dividend = ~a; divisor = ~b;
    cycles = 0;
    while (complete !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(LAT));
    chk({tag, "_quot"}, quotient, exp_q);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(complete), 32'd0);
  endtask

  initial begin
    logic [32:0] r;
    logic [30:0] am, bm;
    logic [31:0] ra, rb, opa, opb, opc;
    logic [32:0] ea, eb, ec;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", quotient, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cmp", 32'(complete), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op(32'd900, 32'd100, 32'h0004_8000, 1'b0, "d900_100");
    do_op(32'd1, 32'd3, 32'h0000_2AAA, 1'b0, "d1_3");
    do_op(32'h8000_0384, 32'd100, 32'h8004_8000, 1'b0, "neg900");
    do_op(32'h8000_0000, 32'd5, 32'h0000_0000, 1'b0, "negzero");
    do_op(32'd7, 32'd0, 32'h7FFF_FFFF, 1'b1, "div0");
    do_op(32'h0001_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, "magovf");
    do_op(32'h8000_0007, 32'd0, 32'hFFFF_FFFF, 1'b1, "negdiv0");

    for (int i = 0; i < 24; i++) begin
      am = 31'($urandom) >> $urandom_range(30, 0);
      bm = ($urandom_range(7, 0) == 0) ? 31'd0 : (31'($urandom) >> $urandom_range(30, 0));
      ra = {1'($urandom), am};
      rb = {1'($urandom), bm};
      r  = model(ra, rb);
      do_op(ra, rb, r[31:0], r[32], $sformatf("rand%0d", i));
    end

    // Held start: three back-to-back results, operands swapped mid-flight.
    opa = 32'd900;       opb = 32'h8000_0064;  opc = 32'd12345;
    ea = model(opa, 32'd100);
    eb = model(opb, 32'd7);
    ec = model(opc, 32'h8000_0003);
    @(negedge clk);
    dividend = opa; divisor = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 145; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin dividend = opb; divisor = 32'd7; end
      if (i == 60) begin dividend = opc; divisor = 32'h8000_0003; end
      if (i == 100) start = 1'b0;
      chk($sformatf("held_cmp%0d", i), 32'(complete), 32'(i == 47 || i == 95 || i == 143));
      if (i == 47)  begin chk("held_q1", quotient, ea[31:0]); chk("held_o1", 32'(overflow), 32'(ea[32])); end
      if (i == 95)  begin chk("held_q2", quotient, eb[31:0]); chk("held_o2", 32'(overflow), 32'(eb[32])); end
      if (i == 143) begin chk("held_q3", quotient, ec[31:0]); chk("held_o3", 32'(overflow), 32'(ec[32])); end
    end
    repeat (2) @(posedge clk);

    // Reset at edge k+20 aborts the operation with no completion.
    @(negedge clk);
    dividend = 32'd900; divisor = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_quot", quotient, 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_cmp", 32'(complete), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (complete !== 1'b0) chk("abort_no_cmp", 32'(complete), 32'd0);
    end
    chk("abort_idle_cmp", 32'(complete), 32'd0);
    do_op(32'd1, 32'd3, 32'h0000_2AAA, 1'b0, "post_rst");

    // Start coincident with reset is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd1;
    @(posedge clk); #1;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
